// File: rtl/riscv_lsu_pkg.sv
// riscv_lsu_pkg
//   Shared definitions for the load/store unit: RISC-V funct3 encodings,
//   memory size codes, FSM state enum and small decode helpers.
package riscv_lsu_pkg;

  // Load encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  // Store encodings
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Memory size codes
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } lsu_state_e;

  // Latched request attributes carried from IDLE into ISSUE/RESP
  typedef struct packed {
    logic       we;
    logic [2:0] funct3;
    logic       err;
  } lsu_op_t;

  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    if (we) return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
    return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
           (f3 == F3_LBU) || (f3 == F3_LHU);
  endfunction

  // funct3[1:0] is the size code directly; the unused 2'b11 pattern only
  // occurs on illegal requests, which never write, so it folds onto WORD.
  function automatic logic [1:0] f3_size(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return SZ_BYTE;
      2'b01:   return SZ_HALF;
      default: return SZ_WORD;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// lsu_load_align
//   Combinational load-result extender. Takes the memory word
//   {b[a+3],b[a+2],b[a+1],b[a]} and the load funct3 and produces the
//   sign/zero-extended register value.
//   Ports:
//     funct3  in  3     load funct3
//     word    in  32    raw memory read word
//     result  out XLEN  extended load data
module lsu_load_align
  import riscv_lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [31:0]     word,
  output logic [XLEN-1:0] result
);

  always_comb begin
    result = '0;
    case (funct3)
      F3_LB:   result = {{(XLEN-8){word[7]}}, word[7:0]};
      F3_LBU:  result = {{(XLEN-8){1'b0}}, word[7:0]};
      F3_LH:   result = {{(XLEN-16){word[15]}}, word[15:0]};
      F3_LHU:  result = {{(XLEN-16){1'b0}}, word[15:0]};
      F3_LW:   result = word[XLEN-1:0];
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit
//   Pipeline-side initiator for the byte-addressable data memory. One
//   request per transaction: IDLE accepts, ISSUE drives the memory for one
//   cycle (write strobe for legal stores, read capture for loads), RESP holds
//   the response until the core takes it.
//   Optional feature macro: MISALIGN_TRAP_EN -- when defined, misaligned half
//   and word accesses are turned into error responses at accept time.
//   Ports:
//     clk, rst                 clock, synchronous active-high reset
//     req_valid/req_ready      request handshake
//     req_we, req_funct3       store flag, RISC-V funct3
//     req_addr, req_wdata      byte address, store data
//     resp_valid/resp_ready    response handshake
//     resp_rdata, resp_err     extended load data (0 for stores/errors), error
//     mem_wr, mem_byte         memory write strobe, size code
//     mem_addr, mem_wdata      memory address, write data
//     mem_rdata                memory combinational read word
module load_store_unit
  import riscv_lsu_pkg::*;
#(
  parameter int AWIDTH = 32,
  parameter int XLEN   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [AWIDTH-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [XLEN-1:0]   resp_rdata,
  output logic              resp_err,
  output logic              mem_wr,
  output logic [1:0]        mem_byte,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  lsu_state_e      state;
  lsu_op_t         op;
  logic            acc_err;
  logic [XLEN-1:0] load_ext;

  // Error decision is made on the incoming request so it can gate mem_wr,
  // which is registered at accept time and therefore high exactly in ISSUE.
  always_comb begin
    acc_err = !f3_legal(req_we, req_funct3);
`ifdef MISALIGN_TRAP_EN
    case (f3_size(req_funct3))
      SZ_HALF: if (req_addr[0])          acc_err = 1'b1;
      SZ_WORD: if (req_addr[1:0] != '0)  acc_err = 1'b1;
      default: ;
    endcase
`endif
  end

  lsu_load_align #(.XLEN(XLEN)) u_align (
    .funct3 (op.funct3),
    .word   (mem_rdata),
    .result (load_ext)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      op         <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      mem_wr     <= 1'b0;
      mem_addr   <= '0;
      mem_byte   <= SZ_WORD;
      mem_wdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            op.we     <= req_we;
            op.funct3 <= req_funct3;
            op.err    <= acc_err;
            mem_addr  <= req_addr;
            mem_byte  <= f3_size(req_funct3);
            mem_wdata <= req_wdata[31:0];
            mem_wr    <= req_we && !acc_err;
            req_ready <= 1'b0;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          // mem_rdata reflects mem_addr this cycle; capture the load result.
          mem_wr     <= 1'b0;
          resp_valid <= 1'b1;
          resp_err   <= op.err;
          resp_rdata <= (!op.we && !op.err) ? load_ext : '0;
          state      <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            state      <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit
//   Self-checking bench: a byte-array memory is attached to the mem_* port,
//   and a separate reference byte array is updated from request-level
//   semantics to predict every load result and error flag.
module tb_load_store_unit;
  import riscv_lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_wr;
  logic [1:0]  mem_byte;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  load_store_unit #(.AWIDTH(32), .XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_wr(mem_wr), .mem_byte(mem_byte), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // ---------------- memory attached to the DUT ----------------
  logic [7:0] mem     [4096];
  logic [7:0] ref_mem [4096];
  logic       mem_init = 1'b0;

  function automatic int ix(input logic [31:0] a, input int k);
    return (int'(a[11:0]) + k) % 4096;
  endfunction

  assign mem_rdata = {mem[ix(mem_addr, 3)], mem[ix(mem_addr, 2)],
                      mem[ix(mem_addr, 1)], mem[ix(mem_addr, 0)]};

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 4096; i++) mem[i] <= ref_mem[i];
    end else if (mem_wr) begin
      mem[ix(mem_addr, 0)] <= mem_wdata[7:0];
      if (mem_byte != 2'd0) mem[ix(mem_addr, 1)] <= mem_wdata[15:8];
      if (mem_byte == 2'd2) begin
        mem[ix(mem_addr, 2)] <= mem_wdata[23:16];
        mem[ix(mem_addr, 3)] <= mem_wdata[31:24];
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic int nbytes(input logic [2:0] f3);
    return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
  endfunction

  function automatic bit ref_err(input logic we, input logic [2:0] f3,
                                 input logic [31:0] a);
    bit bad;
    bad = we ? !(f3 inside {3'd0, 3'd1, 3'd2})
             : !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
`ifdef MISALIGN_TRAP_EN
    if (!bad && (a % nbytes(f3)) != 0) bad = 1'b1;
`else
    if (a == 32'hFFFF_FFFF && f3 == 3'd7) bad = 1'b1; // already illegal; keeps a used
`endif
    return bad;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3,
                                           input logic [31:0] a);
    int unsigned v = 0;
    int n = nbytes(f3);
    for (int k = 0; k < n; k++) v = v + (int'(ref_mem[ix(a, k)]) << (8 * k));
    // signed loads: subtract 2^bits when the top bit is set
    if (!f3[2] && n == 1 && v >= 128)   v = v - 256;
    if (!f3[2] && n == 2 && v >= 32768) v = v - 65536;
    return v;
  endfunction

  task automatic ref_store(input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd);
    for (int k = 0; k < nbytes(f3); k++) ref_mem[ix(a, k)] = wd[8*k +: 8];
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One complete transaction starting and ending at a negedge in IDLE.
  task automatic txn(input logic we, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] wd,
                     input int hold, output logic [31:0] got,
                     output logic got_err);
    bit          e;
    logic [31:0] er;
    e  = ref_err(we, f3, a);
    er = (we || e) ? 32'h0 : ref_load(f3, a);
    chk("req_ready_idle", {31'h0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3;
    req_addr = a; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0;
    chk("mem_wr_issue", {31'h0, mem_wr}, {31'h0, we && !e});
    chk("mem_addr", mem_addr, a);
    if (!e) chk("mem_byte", {30'h0, mem_byte}, {30'h0, f3[1:0]});
    if (we && !e) begin
      chk("mem_wdata", mem_wdata, wd);
      ref_store(f3, a, wd);
    end
    chk("req_ready_issue", {31'h0, req_ready}, 32'd0);
    chk("resp_valid_issue", {31'h0, resp_valid}, 32'd0);
    @(negedge clk);
    chk("resp_valid", {31'h0, resp_valid}, 32'd1);
    chk("resp_rdata", resp_rdata, er);
    chk("resp_err", {31'h0, resp_err}, {31'h0, e});
    chk("mem_wr_resp", {31'h0, mem_wr}, 32'd0);
    got = resp_rdata; got_err = resp_err;
    for (int i = 0; i < hold; i++) begin
      // a competing request must be ignored while the response is pending
      req_valid = 1'b1; req_we = 1'b0; req_funct3 = F3_LW;
      req_addr = a ^ 32'h40;
      @(negedge clk);
      chk("hold_valid", {31'h0, resp_valid}, 32'd1);
      chk("hold_rdata", resp_rdata, er);
      chk("hold_req_ready", {31'h0, req_ready}, 32'd0);
      chk("hold_mem_addr", mem_addr, a);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("resp_valid_done", {31'h0, resp_valid}, 32'd0);
    chk("req_ready_done", {31'h0, req_ready}, 32'd1);
    req_valid = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req_ready"},  {31'h0, req_ready},  32'd1);
    chk({tag, "_resp_valid"}, {31'h0, resp_valid}, 32'd0);
    chk({tag, "_resp_rdata"}, resp_rdata, 32'd0);
    chk({tag, "_resp_err"},   {31'h0, resp_err},   32'd0);
    chk({tag, "_mem_wr"},     {31'h0, mem_wr},     32'd0);
    chk({tag, "_mem_addr"},   mem_addr, 32'd0);
    chk({tag, "_mem_byte"},   {30'h0, mem_byte},   32'd2);
    chk({tag, "_mem_wdata"},  mem_wdata, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] r;
    logic        re;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
    for (int i = 0; i < 4096; i++) ref_mem[i] = 8'($urandom);
    mem_init = 1'b1;
    repeat (2) @(negedge clk);
    mem_init = 1'b0;
    chk_reset_vals("reset");
    rst = 1'b0;
    @(negedge clk);

    // directed: word store then loads of every width
    txn(1'b1, F3_SW, 32'h100, 32'hDEADBEEF, 0, r, re);
    txn(1'b0, F3_LW, 32'h100, 32'h0, 0, r, re);
    chk("lw_deadbeef", r, 32'hDEADBEEF);
    chk("lw_err", {31'h0, re}, 32'd0);
    txn(1'b0, F3_LB, 32'h100, 32'h0, 0, r, re);
    chk("lb", r, 32'hFFFFFFEF);
    txn(1'b0, F3_LBU, 32'h100, 32'h0, 0, r, re);
    chk("lbu", r, 32'h000000EF);
    txn(1'b0, F3_LH, 32'h102, 32'h0, 0, r, re);
    chk("lh", r, 32'hFFFFDEAD);
    txn(1'b0, F3_LHU, 32'h102, 32'h0, 0, r, re);
    chk("lhu", r, 32'h0000DEAD);
    txn(1'b1, F3_SB, 32'h101, 32'h12345678, 0, r, re);
    chk("sb_ack_rdata", r, 32'h0);
    txn(1'b0, F3_LW, 32'h100, 32'h0, 0, r, re);
    chk("lw_after_sb", r, 32'hDEAD78EF);

    // illegal funct3 and misaligned word
    txn(1'b0, 3'b011, 32'h100, 32'h0, 0, r, re);
    chk("ill_err", {31'h0, re}, 32'd1);
    chk("ill_rdata", r, 32'h0);
    txn(1'b1, 3'b100, 32'h100, 32'hFFFFFFFF, 0, r, re);
    chk("ill_store_err", {31'h0, re}, 32'd1);
    txn(1'b0, F3_LW, 32'h102, 32'h0, 0, r, re);
`ifdef MISALIGN_TRAP_EN
    chk("misalign_err", {31'h0, re}, 32'd1);
`else
    chk("misalign_ok", {31'h0, re}, 32'd0);
`endif

    // backpressure: response held 5 cycles
    txn(1'b0, F3_LW, 32'h100, 32'h0, 5, r, re);
    chk("stall_rdata", r, 32'hDEAD78EF);

    // reset during ISSUE of a store
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_SW;
    req_addr = 32'h200; req_wdata = 32'hCAFEF00D;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rst_issue_mem_wr", {31'h0, mem_wr}, 32'd1);
    ref_store(F3_SW, 32'h200, 32'hCAFEF00D); // memory samples this strobe
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_reset_vals("rst_issue");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_resp_valid", {31'h0, resp_valid}, 32'd0);
      chk("post_rst_mem_wr", {31'h0, mem_wr}, 32'd0);
      chk("post_rst_req_ready", {31'h0, req_ready}, 32'd1);
    end

    // randomized traffic against the reference model
    for (int n = 0; n < 60; n++) begin
      logic        we;
      logic [2:0]  f3;
      logic [31:0] a;
      we = 1'($urandom);
      f3 = ($urandom_range(0, 9) == 0) ? 3'($urandom) :
           (we ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 4)));
      if (!we && f3 == 3'd3) f3 = F3_LBU;
      a  = $urandom;
      if ($urandom_range(0, 1) == 1) a = {a[31:2], 2'b00};
      txn(we, f3, a, $urandom, $urandom_range(0, 2), r, re);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // overall time bound
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
